// File: rtl/router_ctrl_fsm_n_pkg.sv
// Shared types and parameter checks for the N-channel router control FSM.
// The optional wait timeout is enabled by defining ROUTER_WAIT_TIMEOUT_EN.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        WAIT_TILL_EMPTY    = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        LOAD_AFTER_FULL    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    function automatic bit params_legal(int n_ch, int addr_w, int wait_tmo);
        return (n_ch >= 2) && (n_ch <= 16) && (addr_w >= 1) && (addr_w <= 30) &&
               ((1 << addr_w) >= n_ch) && (wait_tmo >= 1);
    endfunction

endpackage

// File: rtl/router_ctrl_fsm_n_if.sv
// Signal bundle between the input synchroniser/FIFO side and the router control FSM.
// The FSM itself lives in router_ctrl_fsm_n.sv; the wait timeout is gated by ROUTER_WAIT_TIMEOUT_EN.
interface router_ctrl_fsm_n_if
    import router_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int ADDR_W = 2
);
    // pkt_valid qualifies din only in DECODE_ADDRESS; there is no ready, the
    // state outputs (busy, wr_en_req, ...) are the only flow control back to the source.
    logic              pkt_valid;
    logic [ADDR_W-1:0] din;
    logic [N_CH-1:0]   fifo_empty;
    logic [N_CH-1:0]   fifo_full;
    logic [N_CH-1:0]   soft_rst;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              wr_en_req;
    logic              busy;
    logic [N_CH-1:0]   dest_sel;
    logic              addr_err;
    logic              drop;
    state_t            state_dbg;

    modport master (
        output pkt_valid, din, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               wr_en_req, busy, dest_sel, addr_err, drop, state_dbg
    );

    modport slave (
        input  pkt_valid, din, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
        output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               wr_en_req, busy, dest_sel, addr_err, drop, state_dbg
    );

endinterface

// File: rtl/router_ctrl_fsm_n_wait_timer.sv
// Cycle counter bounding the time spent in WAIT_TILL_EMPTY.
// Only present in builds with ROUTER_WAIT_TIMEOUT_EN defined.
`ifdef ROUTER_WAIT_TIMEOUT_EN
module router_wait_timer #(
    parameter int WAIT_TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(WAIT_TMO + 1);
    localparam logic [W-1:0] LAST = W'(WAIT_TMO - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + W'(1);
        end
    end

    // High during the WAIT_TMO-th wait cycle; an empty FIFO that cycle still wins.
    assign expired = en && (cnt == LAST);

endmodule
`endif

// File: rtl/router_ctrl_fsm_n.sv
// Write-side control FSM for an N-output packet router.
// Define ROUTER_WAIT_TIMEOUT_EN to bound WAIT_TILL_EMPTY and drop packets that stall there.
module router_ctrl_fsm_n
    import router_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_TMO = 255
) (
    input logic              clk,
    input logic              rst,
    router_ctrl_fsm_n_if.slave bus
);

    if (!params_legal(N_CH, ADDR_W, WAIT_TMO)) begin : g_param_err
        $error("router_ctrl_fsm_n: illegal N_CH/ADDR_W/WAIT_TMO");
    end

    state_t          state;
    logic [N_CH-1:0] dest_sel;
    logic            addr_err;
    logic            drop;
    logic [N_CH-1:0] hdr_onehot;
    logic            hdr_legal;
    logic            hdr_empty;
    logic            dest_full;
    logic            dest_empty;
    logic            dest_soft;
    logic            wait_expired;

    // An out-of-range address shifts the one out of the vector, so zero means illegal.
    assign hdr_onehot = N_CH'(1) << bus.din;
    assign hdr_legal  = |hdr_onehot;
    assign hdr_empty  = |(hdr_onehot & bus.fifo_empty);
    assign dest_full  = |(dest_sel & bus.fifo_full);
    assign dest_empty = |(dest_sel & bus.fifo_empty);
    assign dest_soft  = |(dest_sel & bus.soft_rst);

`ifdef ROUTER_WAIT_TIMEOUT_EN
    router_wait_timer #(
        .WAIT_TMO (WAIT_TMO)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != WAIT_TILL_EMPTY),
        .en      (state == WAIT_TILL_EMPTY),
        .expired (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DECODE_ADDRESS;
            dest_sel <= '0;
            addr_err <= 1'b0;
            drop     <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            drop     <= 1'b0;
            if ((state != DECODE_ADDRESS) && (state != DROP_PACKET) && dest_soft) begin
                state    <= DECODE_ADDRESS;
                dest_sel <= '0;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (bus.pkt_valid) begin
                            if (hdr_legal) begin
                                dest_sel <= hdr_onehot;
                                state    <= hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                            end else begin
                                state    <= DROP_PACKET;
                                addr_err <= 1'b1;
                            end
                        end
                    end
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (dest_full)          state <= FIFO_FULL_STATE;
                        else if (!bus.pkt_valid) state <= LOAD_PARITY;
                    end
                    WAIT_TILL_EMPTY: begin
                        if (dest_empty) begin
                            state <= LOAD_FIRST_DATA;
                        end else if (wait_expired) begin
                            state    <= DROP_PACKET;
                            dest_sel <= '0;
                            drop     <= 1'b1;
                        end
                    end
                    FIFO_FULL_STATE: begin
                        if (!dest_full) state <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (bus.parity_done) begin
                            state    <= DECODE_ADDRESS;
                            dest_sel <= '0;
                        end else if (bus.low_pkt_valid) begin
                            state <= LOAD_PARITY;
                        end else begin
                            state <= LOAD_DATA;
                        end
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        if (dest_full) begin
                            state <= FIFO_FULL_STATE;
                        end else begin
                            state    <= DECODE_ADDRESS;
                            dest_sel <= '0;
                        end
                    end
                    DROP_PACKET: begin
                        if (!bus.pkt_valid) state <= DECODE_ADDRESS;
                    end
                    default: begin
                        state    <= DECODE_ADDRESS;
                        dest_sel <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.detect_addr = (state == DECODE_ADDRESS);
    assign bus.lfd_state   = (state == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state == LOAD_DATA);
    assign bus.laf_state   = (state == LOAD_AFTER_FULL);
    assign bus.full_state  = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign bus.wr_en_req   = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
    assign bus.busy        = (state != DECODE_ADDRESS) && (state != LOAD_DATA) &&
                             (state != DROP_PACKET);
    assign bus.dest_sel    = dest_sel;
    assign bus.addr_err    = addr_err;
    assign bus.drop        = drop;
    assign bus.state_dbg   = state;

endmodule
